keypad_hex_entry: RTL and testbench
===================================

Name: keypad_hex_entry

Overview:
Input-side counterpart to the seven-segment display path. The display path scans anodes outward; this block scans the rows of a 4x4 matrix keypad and reads the columns back in. It debounces each press, translates it to a hex digit, and shifts that digit into a 32-bit entry register. The register is the value the board feeds to the CPU, and the display shows it back.

Parameters:
SCAN_DIV, 50000, clk cycles per row dwell. One scan tick is issued per dwell. Must be >= 2.
DEBOUNCE_TICKS, 4, consecutive stable scan ticks needed to accept a press or a release. Must be >= 1.

Ports:
clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
kp_row  out  4  row drive, active-low, exactly one bit low at any time
kp_col  in  4  column sense, active-low (external pull-ups), asynchronous
clr  in  1  synchronous clear of the entry register
key_valid  out  1  one-cycle pulse when a debounced press is accepted
key_code  out  4  hex value of the last accepted key, held until the next accept
value  out  32  entry register, newest digit in [3:0]

Behaviour:
- Reset (sampled on a clk edge while Reset=1):
  - kp_row=4'b1110 (row 0); value=0; key_valid=0; key_code=0.
  - State=SCAN; divider=0; row index=0; debounce count=0; synchroniser flops=4'b1111.
- Synchroniser: kp_col passes through 2 flops before any use. Only the synchronised value (scol) is used.
- Tick: the divider counts 0..SCAN_DIV-1 and wraps. tick=1 in the cycle where divider==SCAN_DIV-1. scol is sampled only on tick cycles.
- Row drive: kp_row = ~(4'b0001 << row). The row index changes only on a tick, and only in state SCAN.
- State SCAN:
  - On tick with scol==4'b1111: row <= row+1 (wraps 3->0).
  - On tick with any scol bit low: capture cand_row=row and cand_col=lowest low bit index. Set cnt=1, go to CONFIRM. Row is frozen.
- State CONFIRM:
  - On tick with scol[cand_col]==0: cnt++. Other column bits are ignored.
  - When cnt reaches DEBOUNCE_TICKS:
    - key_valid=1 for the next cycle only.
    - key_code = map(cand_row, cand_col).
    - value <= {value[27:0], code}.
    - Go to HELD with cnt=0.
  - On tick with scol[cand_col]==1: cnt=0, row <= row+1, go to SCAN.
  - With DEBOUNCE_TICKS=1, accept happens on the capture tick itself: the transition goes SCAN->HELD directly.
- State HELD:
  - Row stays frozen. On tick with scol[cand_col]==1: cnt++. On tick with scol[cand_col]==0: cnt=0.
  - When cnt reaches DEBOUNCE_TICKS: cnt=0, row <= row+1, go to SCAN.
  - No repeat: a held key produces exactly one key_valid.
- Key map (row, col -> code):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- Latency: key_valid rises 1 cycle after the tick that completes DEBOUNCE_TICKS stable samples. value updates in the same cycle as key_valid.
- value shifting: after 8 digits, each new digit discards value[31:28]. There is no saturation.
- clr=1 sets value=0 on that edge.
  - clr has priority over a simultaneous shift; that digit is lost from value.
  - key_valid and key_code still update.
  - clr does not affect the FSM.
- Multiple keys: the lowest column on the active row wins at capture. A second key pressed in another row is not seen until the return to SCAN.
- Reset mid-operation discards any in-flight press: no key_valid is emitted and the FSM restarts from SCAN at row 0.

Decomposition:
- Package keypad_pkg holds:
  - the state enum (SCAN, CONFIRM, HELD);
  - the 16-entry key map constant, indexed by {row,col};
  - the row/col index width constant (2).
- One sub-module, kp_tick_gen: parameterised by SCAN_DIV; outputs the 1-cycle tick; synchronous reset.
- The synchroniser, FSM and entry register stay in keypad_hex_entry.

Test Plan (SCAN_DIV=4, DEBOUNCE_TICKS=3):
- Reset, no keys -> kp_row cycles 1110, 1101, 1011, 0111, 1110, changing every 4 clk; key_valid stays 0; value=0.
- Model holds "5" (r1,c1) low while row1 is driven, release after 10 ticks -> exactly one key_valid pulse with key_code=5. Pulse occurs 3 ticks (+1 cycle) after capture. value=0x00000005. Scanning resumes at row2 only after 3 released ticks.
- Enter 1,2,3,A,4,5,6,B,7 -> value=0x23A456B7 (leading '1' shifted out).
- Bounce: "9" low for 1 tick, high for 1 tick, then low steadily -> exactly one key_valid, key_code=9, value=0x00000009.
- clr asserted on the same cycle as the accept of key "C" with value=0x12 -> value=0; key_valid=1; key_code=C.
- Reset asserted while in CONFIRM for "#" -> no key_valid; kp_row=1110 on the next cycle; value=0. After release and a re-press, key_code=F.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad entry path.
// Key map is indexed by {row, col}; entry 0 is row 0 / column 0.
package keypad_pkg;

    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        HELD
    } kp_state_t;

    // Rows: 1 2 3 A / 4 5 6 B / 7 8 9 C / *(E) 0 #(F) D
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [IDX_W-1:0] lowest_low(input logic [3:0] col);
        logic [IDX_W-1:0] idx;
        if (!col[0])      idx = 2'd0;
        else if (!col[1]) idx = 2'd1;
        else if (!col[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/kp_tick_gen.sv
// Row-dwell divider: counts 0..SCAN_DIV-1 and flags the last count
// as a one-cycle scan tick.
module kp_tick_gen #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    localparam int unsigned      DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign o_tick = (r_div == DIV_LAST);

endmodule

// File: rtl/keypad_hex_entry.sv
// Scans a 4x4 active-low keypad, debounces press and release, and
// shifts each accepted hex digit into a 32-bit entry register.
module keypad_hex_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        Reset,
    output logic [3:0]  kp_row,
    input  logic [3:0]  kp_col,
    input  logic        clr,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] value
);

    localparam int unsigned      CNT_W             = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE          = CNT_W'(DEBOUNCE_TICKS);
    localparam bit               ACCEPT_ON_CAPTURE = (DEBOUNCE_TICKS == 1);

    logic             w_tick;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    kp_state_t        r_state;
    kp_state_t        w_state_nx;
    logic [IDX_W-1:0] r_row;
    logic [IDX_W-1:0] w_row_nx;
    logic [IDX_W-1:0] r_cand_row;
    logic [IDX_W-1:0] w_cand_row_nx;
    logic [IDX_W-1:0] r_cand_col;
    logic [IDX_W-1:0] w_cand_col_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_cand_bit;
    logic             w_accept;
    logic [3:0]       w_code;
    logic             r_key_valid;
    logic [3:0]       r_key_code;
    logic [31:0]      r_value;

    kp_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .i_clk   (clk),
        .i_reset (Reset),
        .o_tick  (w_tick)
    );

    // State register plus the datapath registers it steers
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_sync1     <= 4'b1111;
            r_sync2     <= 4'b1111;
            r_state     <= SCAN;
            r_row       <= '0;
            r_cand_row  <= '0;
            r_cand_col  <= '0;
            r_cnt       <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_value     <= '0;
        end else begin
            r_sync1     <= kp_col;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nx;
            r_row       <= w_row_nx;
            r_cand_row  <= w_cand_row_nx;
            r_cand_col  <= w_cand_col_nx;
            r_cnt       <= w_cnt_nx;
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key_code <= w_code;
            end
            // clr wins over a coincident shift; that digit never lands
            if (clr) begin
                r_value <= '0;
            end else if (w_accept) begin
                r_value <= {r_value[27:0], w_code};
            end
        end
    end

    // Next-state logic; everything moves only on a scan tick
    always_comb begin
        w_state_nx    = r_state;
        w_row_nx      = r_row;
        w_cand_row_nx = r_cand_row;
        w_cand_col_nx = r_cand_col;
        w_cnt_nx      = r_cnt;
        w_accept      = 1'b0;
        w_cnt_inc     = r_cnt + 1'b1;
        w_cand_bit    = r_sync2[r_cand_col];
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (r_sync2 == 4'b1111) begin
                        w_row_nx = r_row + 1'b1;
                    end else begin
                        w_cand_row_nx = r_row;
                        w_cand_col_nx = lowest_low(r_sync2);
                        if (ACCEPT_ON_CAPTURE) begin
                            w_accept   = 1'b1;
                            w_cnt_nx   = '0;
                            w_state_nx = HELD;
                        end else begin
                            w_cnt_nx   = CNT_W'(1);
                            w_state_nx = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (!w_cand_bit) begin
                        if (w_cnt_inc == CNT_DONE) begin
                            w_accept   = 1'b1;
                            w_cnt_nx   = '0;
                            w_state_nx = HELD;
                        end else begin
                            w_cnt_nx = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nx   = '0;
                        w_row_nx   = r_row + 1'b1;
                        w_state_nx = SCAN;
                    end
                end
                HELD: begin
                    if (w_cand_bit) begin
                        if (w_cnt_inc == CNT_DONE) begin
                            w_cnt_nx   = '0;
                            w_row_nx   = r_row + 1'b1;
                            w_state_nx = SCAN;
                        end else begin
                            w_cnt_nx = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nx = '0;
                    end
                end
                default: begin
                    w_cnt_nx   = '0;
                    w_state_nx = SCAN;
                end
            endcase
        end
        w_code = KEY_MAP[{w_cand_row_nx, w_cand_col_nx}];
    end

    always_comb begin
        kp_row    = ~(4'b0001 << r_row);
        key_valid = r_key_valid;
        key_code  = r_key_code;
        value     = r_value;
    end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Bench for keypad_hex_entry: a behavioural keypad matrix drives kp_col
// from kp_row and a per-key pressed mask.
module tb_keypad_hex_entry;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;

    logic        clk = 1'b0;
    logic        Reset;
    logic        clr;
    logic [3:0]  kp_row;
    logic [3:0]  kp_col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] value;
    logic [15:0] pressed;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          clr_first;
        int          row;
        int          col;
        logic [3:0]  code;
        logic [31:0] val;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    keypad_hex_entry #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEB)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .kp_row    (kp_row),
        .kp_col    (kp_col),
        .clr       (clr),
        .key_valid (key_valid),
        .key_code  (key_code),
        .value     (value)
    );

    always_comb begin
        kp_col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (!kp_row[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[r*4+c]) kp_col[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Returns on the first negedge after the scan enters row r
    task automatic wait_row(input int r, input string name);
        logic [3:0] want;
        logic [3:0] prev;
        bit         ok;
        want = ~(4'b0001 << r);
        prev = kp_row;
        ok   = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (kp_row == want && prev != want) ok = 1'b1;
            prev = kp_row;
        end
        check({name, " row entry"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr value", value, 32'd0);
    endtask

    task automatic release_and_leave(input int r, input int extra_kv, input string name);
        logic [3:0] held_row;
        int         kv;
        bit         moved;
        held_row = ~(4'b0001 << r);
        kv       = extra_kv;
        moved    = 1'b0;
        pressed  = '0;
        for (int i = 0; i < 40 && !moved; i++) begin
            @(negedge clk);
            if (key_valid) kv++;
            if (kp_row != held_row) moved = 1'b1;
        end
        check({name, " released"}, {31'd0, moved}, 32'd1);
        check({name, " repeat pulses"}, kv, 0);
    endtask

    task automatic press_key(input int r, input int c, input logic [3:0] code,
                             input logic [31:0] val, input string name);
        bit seen;
        int extra;
        wait_row(r, name);
        pressed[r*4+c] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (key_valid) seen = 1'b1;
        end
        check({name, " key_valid"}, {31'd0, seen}, 32'd1);
        check({name, " key_code"}, {28'd0, key_code}, {28'd0, code});
        check({name, " value"}, value, val);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (key_valid) extra++;
        end
        release_and_leave(r, extra, name);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         kv;
        int         first_kv;
        int         first_move;
        logic [3:0] row_after;

        vecs[0]  = '{1'b1, 0, 0, 4'h1, 32'h00000001};
        vecs[1]  = '{1'b0, 0, 1, 4'h2, 32'h00000012};
        vecs[2]  = '{1'b0, 0, 2, 4'h3, 32'h00000123};
        vecs[3]  = '{1'b0, 0, 3, 4'hA, 32'h0000123A};
        vecs[4]  = '{1'b0, 1, 0, 4'h4, 32'h000123A4};
        vecs[5]  = '{1'b0, 1, 1, 4'h5, 32'h00123A45};
        vecs[6]  = '{1'b0, 1, 2, 4'h6, 32'h0123A456};
        vecs[7]  = '{1'b0, 1, 3, 4'hB, 32'h123A456B};
        vecs[8]  = '{1'b0, 2, 0, 4'h7, 32'h23A456B7};
        vecs[9]  = '{1'b1, 2, 1, 4'h8, 32'h00000008};
        vecs[10] = '{1'b0, 2, 2, 4'h9, 32'h00000089};
        vecs[11] = '{1'b0, 2, 3, 4'hC, 32'h0000089C};
        vecs[12] = '{1'b0, 3, 0, 4'hE, 32'h000089CE};
        vecs[13] = '{1'b0, 3, 1, 4'h0, 32'h00089CE0};
        vecs[14] = '{1'b0, 3, 2, 4'hF, 32'h0089CE0F};
        vecs[15] = '{1'b0, 3, 3, 4'hD, 32'h089CE0FD};

        Reset   = 1'b1;
        clr     = 1'b0;
        pressed = '0;

        // Reset state and idle scan
        repeat (3) @(posedge clk);
        @(negedge clk);
        Reset = 1'b0;
        check("reset kp_row", {28'd0, kp_row}, 32'h0000000E);
        check("reset value", value, 32'd0);
        check("reset key_valid", {31'd0, key_valid}, 32'd0);
        check("reset key_code", {28'd0, key_code}, 32'd0);
        kv = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (key_valid) kv++;
            check($sformatf("idle kp_row k=%0d", k), {28'd0, kp_row},
                  {28'd0, ~(4'b0001 << ((k / 4) % 4))});
        end
        check("idle key_valid pulses", kv, 0);
        check("idle value", value, 32'd0);

        // Key 5 timing: press on row-1 entry, release after 10 ticks
        wait_row(1, "key5");
        pressed[5] = 1'b1;
        kv = 0; first_kv = 0; first_move = 0; row_after = 4'b1101;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (key_valid) begin
                kv++;
                if (first_kv == 0) first_kv = i;
            end
            if (first_move == 0 && kp_row != 4'b1101) begin
                first_move = i;
                row_after  = kp_row;
            end
            if (i == 40) pressed = '0;
        end
        check("key5 pulse count", kv, 1);
        check("key5 pulse cycle", first_kv, 12);
        check("key5 key_code", {28'd0, key_code}, 32'h5);
        check("key5 value", value, 32'h5);
        check("key5 rescan cycle", first_move, 52);
        check("key5 rescan row", {28'd0, row_after}, 32'hB);

        // Table-driven digit entry
        for (int v = 0; v < 16; v++) begin
            if (vecs[v].clr_first) pulse_clr();
            press_key(vecs[v].row, vecs[v].col, vecs[v].code, vecs[v].val,
                      $sformatf("vec%0d", v));
        end

        // Bounce on key 9: low 1 tick, high 1 tick, then low steadily
        pulse_clr();
        wait_row(2, "bounce");
        pressed[10] = 1'b1;
        kv = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (key_valid) kv++;
            if (i == 4) pressed = '0;
            if (i == 8) pressed[10] = 1'b1;
        end
        check("bounce pulse count", kv, 1);
        check("bounce key_code", {28'd0, key_code}, 32'h9);
        check("bounce value", value, 32'h9);
        release_and_leave(2, 0, "bounce");

        // clr coincident with accept of key C
        pulse_clr();
        press_key(0, 0, 4'h1, 32'h1, "pre1");
        press_key(0, 1, 4'h2, 32'h12, "pre2");
        wait_row(2, "clrC");
        pressed[11] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 11) clr = 1'b1;
        end
        clr = 1'b0;
        check("clrC key_valid", {31'd0, key_valid}, 32'd1);
        check("clrC key_code", {28'd0, key_code}, 32'hC);
        check("clrC value", value, 32'd0);
        release_and_leave(2, 0, "clrC");
        check("clrC value after", value, 32'd0);

        // Reset while confirming '#'
        press_key(0, 0, 4'h1, 32'h1, "pre_rst");
        wait_row(3, "rst");
        pressed[14] = 1'b1;
        repeat (5) @(negedge clk);
        check("rst row frozen", {28'd0, kp_row}, 32'h7);
        Reset = 1'b1;
        @(negedge clk);
        Reset   = 1'b0;
        pressed = '0;
        check("rst kp_row", {28'd0, kp_row}, 32'hE);
        check("rst value", value, 32'd0);
        check("rst key_valid", {31'd0, key_valid}, 32'd0);
        check("rst key_code", {28'd0, key_code}, 32'd0);
        kv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (key_valid) kv++;
        end
        check("rst no pulse", kv, 0);
        press_key(3, 2, 4'hF, 32'hF, "repress");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
